// File: rtl/eq_i2s_tx_if.sv
// Sample stream from the equalizer summing stage into the I2S transmitter.
// Plain valid/ready handshake; a transfer happens on a clock edge with i_valid & o_ready.
interface eq_i2s_tx_if #(
    parameter int ACC_WIDTH = 48
);
    logic signed [ACC_WIDTH-1:0] i_data_audio;
    logic                        i_valid;
    logic                        o_ready;

    modport master (
        output i_data_audio,
        output i_valid,
        input  o_ready
    );

    modport slave (
        input  i_data_audio,
        input  i_valid,
        output o_ready
    );
endinterface

// File: rtl/eq_i2s_tx.sv
// Mono equalizer output -> Philips I2S (same sample in both slots), one-deep holding buffer.
// Optional macro EQ_I2S_TX_SATURATE_EN: saturating narrowing instead of wrap-around truncation.
module eq_i2s_tx #(
    parameter int ACC_WIDTH  = 48,
    parameter int DATA_WIDTH = 24,
    parameter int OUT_SHIFT  = 16,
    parameter int BCLK_DIV   = 4
) (
    input  logic           i_clk,
    input  logic           i_reset_n,
    eq_i2s_tx_if.slave     audio_in,
    output logic           o_i2s_bclk,
    output logic           o_i2s_lrclk,
    output logic           o_i2s_sdata,
    output logic           o_underrun
);

    localparam int DIV_W = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;

    logic [DIV_W-1:0]            div_cnt;
    logic                        bclk;
    logic [5:0]                  bit_cnt;
    logic                        full;
    logic                        primed;
    logic [DATA_WIDTH-1:0]       hold_reg;
    logic [DATA_WIDTH-1:0]       frame_reg;
    logic                        sdata;
    logic                        underrun;

    logic                        div_tc;
    logic                        bclk_fall;
    logic                        frame_start;
    logic                        accept;
    logic signed [ACC_WIDTH-1:0] scaled;
    logic [DATA_WIDTH-1:0]       narrowed;
    logic [5:0]                  bit_nxt;
    logic [4:0]                  slot_p;
    logic [4:0]                  slot_idx;
    logic                        slot_bit;

    assign div_tc      = (div_cnt == DIV_W'(BCLK_DIV - 1));
    assign bclk_fall   = div_tc & bclk;
    assign frame_start = bclk_fall & (bit_cnt == 6'd63);
    assign accept      = audio_in.i_valid & ~full;
    assign scaled      = audio_in.i_data_audio >>> OUT_SHIFT;

`ifdef EQ_I2S_TX_SATURATE_EN
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    always_comb begin
        narrowed = DATA_WIDTH'(scaled);
        if (scaled > SAT_MAX) begin
            narrowed = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else if (scaled < SAT_MIN) begin
            narrowed = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end
    end
`else
    always_comb begin
        narrowed = DATA_WIDTH'(scaled);
    end
`endif

    // SDATA is computed for the slot position the falling edge is about to enter;
    // at p=0 the frame register may be reloading, but p=0 is the delay bit anyway.
    always_comb begin
        bit_nxt  = bit_cnt + 6'd1;
        slot_p   = bit_nxt[4:0];
        slot_idx = 5'(DATA_WIDTH) - slot_p;
        slot_bit = 1'b0;
        if ((slot_p != 5'd0) && (slot_p <= 5'(DATA_WIDTH))) begin
            slot_bit = frame_reg[slot_idx];
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
            bit_cnt <= '0;
            sdata   <= 1'b0;
        end else begin
            if (div_tc) begin
                div_cnt <= '0;
                bclk    <= ~bclk;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
            if (bclk_fall) begin
                bit_cnt <= bit_nxt;
                sdata   <= slot_bit;
            end
        end
    end

    // primed stays low only until the first frame start or first acceptance, which
    // is what keeps the very first (empty) frame start from flagging an underrun.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            full      <= 1'b0;
            primed    <= 1'b0;
            hold_reg  <= '0;
            frame_reg <= '0;
            underrun  <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (accept) begin
                primed <= 1'b1;
            end
            if (frame_start) begin
                primed <= 1'b1;
                if (full) begin
                    frame_reg <= hold_reg;
                    full      <= 1'b0;
                end else begin
                    underrun <= primed | accept;
                end
            end
            if (accept) begin
                hold_reg <= narrowed;
                full     <= 1'b1;
            end
        end
    end

    assign audio_in.o_ready = ~full;
    assign o_i2s_bclk       = bclk;
    assign o_i2s_lrclk      = bit_cnt[5];
    assign o_i2s_sdata      = sdata;
    assign o_underrun       = underrun;

endmodule

// File: tb/tb_eq_i2s_tx.sv
// Directed bench for eq_i2s_tx: captures I2S frames on BCLK rising edges and compares
// against hand-computed slot contents, underrun pulses and handshake timing.
module tb_eq_i2s_tx;
    localparam int ACC_WIDTH  = 48;
    localparam int DATA_WIDTH = 24;
    localparam int OUT_SHIFT  = 16;
    localparam int BCLK_DIV   = 4;
    localparam int FRAME      = 128 * BCLK_DIV;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic bclk, lrclk, sdata, underrun;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [63:0] frame_q[$];
    int          ur_q[$];
    int          align_err = 0;

    always #5 clk = ~clk;

    eq_i2s_tx_if #(.ACC_WIDTH(ACC_WIDTH)) audio_if ();

    eq_i2s_tx #(
        .ACC_WIDTH (ACC_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .OUT_SHIFT (OUT_SHIFT),
        .BCLK_DIV  (BCLK_DIV)
    ) dut (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .audio_in   (audio_if),
        .o_i2s_bclk (bclk),
        .o_i2s_lrclk(lrclk),
        .o_i2s_sdata(sdata),
        .o_underrun (underrun)
    );

    // cycles since reset release: at the negedge after the k-th posedge, cyc == k
    initial begin
        forever begin
            @(posedge clk);
            cyc = rst_n ? cyc + 1 : 0;
        end
    end

    // frame capture: one entry per 64 BCLK rising edges, counted from reset release
    initial begin
        logic [63:0] cur_bits;
        int          idx;
        int          cur_ur;
        logic        prev_bclk;
        cur_bits  = '0;
        idx       = 0;
        cur_ur    = 0;
        prev_bclk = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cur_bits  = '0;
                idx       = 0;
                cur_ur    = 0;
                prev_bclk = 1'b0;
            end else begin
                if (underrun === 1'b1) cur_ur++;
                if (!prev_bclk && bclk) begin
                    cur_bits[63-idx] = sdata;
                    if (lrclk !== idx[5]) align_err++;
                    idx++;
                    if (idx == 64) begin
                        frame_q.push_back(cur_bits);
                        ur_q.push_back(cur_ur);
                        idx    = 0;
                        cur_ur = 0;
                    end
                end
                prev_bclk = bclk;
            end
        end
    end

    initial begin
        #(60000 * 10);
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] exp_frame(input logic [23:0] s);
        logic [31:0] slot;
        slot = {1'b0, s, 7'b0};
        return {slot, slot};
    endfunction

    function automatic logic [63:0] frame_at(input int k);
        if (k < frame_q.size()) return frame_q[k];
        return 'x;
    endfunction

    function automatic int ur_at(input int k);
        if (k < ur_q.size()) return ur_q[k];
        return -1;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst_n                 = 1'b0;
        audio_if.i_valid      = 1'b0;
        audio_if.i_data_audio = '0;
        repeat (5) @(negedge clk);
        frame_q.delete();
        ur_q.delete();
        align_err = 0;
        rst_n     = 1'b1;
    endtask

    task automatic send(input logic [47:0] d, input string name);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        audio_if.i_valid      = 1'b1;
        audio_if.i_data_audio = d;
        for (int n = 0; n < 4 * FRAME; n++) begin
            if (audio_if.o_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end
        audio_if.i_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s accept: got no handshake, expected accept within %0d cycles", name, 4 * FRAME);
        end
    endtask

    task automatic wait_cyc(input int n);
        for (int i = 0; i < 8 * FRAME && cyc < n; i++) @(negedge clk);
        checks++;
        if (cyc !== n) begin
            errors++;
            $display("FAIL wait_cyc: got cyc=%0d, expected %0d", cyc, n);
        end
    endtask

    task automatic wait_frames(input int n);
        for (int i = 0; i < FRAME * (n + 2) && frame_q.size() < n; i++) @(negedge clk);
        checks++;
        if (frame_q.size() < n) begin
            errors++;
            $display("FAIL wait_frames: got %0d frames, expected %0d", frame_q.size(), n);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n                 = 1'b0;
        audio_if.i_valid      = 1'b0;
        audio_if.i_data_audio = '0;
        repeat (5) @(negedge clk);
        checks += 5;
        if (bclk !== 1'b0)  begin errors++; $display("FAIL reset bclk: got %b expected 0", bclk); end
        if (lrclk !== 1'b0) begin errors++; $display("FAIL reset lrclk: got %b expected 0", lrclk); end
        if (sdata !== 1'b0) begin errors++; $display("FAIL reset sdata: got %b expected 0", sdata); end
        if (audio_if.o_ready !== 1'b1) begin errors++; $display("FAIL reset ready: got %b expected 1", audio_if.o_ready); end
        if (underrun !== 1'b0) begin errors++; $display("FAIL reset underrun: got %b expected 0", underrun); end
        frame_q.delete();
        ur_q.delete();
        align_err = 0;
        rst_n     = 1'b1;
        wait_cyc(3);
        checks++;
        if (bclk !== 1'b0) begin errors++; $display("FAIL bclk_cyc3: got %b expected 0", bclk); end
        wait_cyc(4);
        checks++;
        if (bclk !== 1'b1) begin errors++; $display("FAIL bclk_cyc4: got %b expected 1", bclk); end
        wait_frames(3);
        checks += 6;
        if (frame_at(0) !== 64'h0) begin errors++; $display("FAIL reset frame0: got %h expected 0", frame_at(0)); end
        if (frame_at(1) !== 64'h0) begin errors++; $display("FAIL reset frame1: got %h expected 0", frame_at(1)); end
        if (ur_at(0) !== 0) begin errors++; $display("FAIL reset ur0: got %0d expected 0", ur_at(0)); end
        if (ur_at(1) !== 0) begin errors++; $display("FAIL reset first_start_ur: got %0d expected 0", ur_at(1)); end
        if (ur_at(2) !== 1) begin errors++; $display("FAIL reset second_start_ur: got %0d expected 1", ur_at(2)); end
        if (align_err !== 0) begin errors++; $display("FAIL reset lrclk_align: got %0d expected 0", align_err); end
    endtask

    task automatic test_single();
        apply_reset();
        send(48'h0012_3456_0000, "single");
        checks++;
        if (audio_if.o_ready !== 1'b0) begin errors++; $display("FAIL single ready_after_accept: got %b expected 0", audio_if.o_ready); end
        wait_cyc(FRAME - 1);
        checks++;
        if (audio_if.o_ready !== 1'b0) begin errors++; $display("FAIL single ready_before_start: got %b expected 0", audio_if.o_ready); end
        wait_cyc(FRAME);
        checks++;
        if (audio_if.o_ready !== 1'b1) begin errors++; $display("FAIL single ready_after_start: got %b expected 1", audio_if.o_ready); end
        wait_frames(2);
        checks += 3;
        if (frame_at(0) !== 64'h0) begin errors++; $display("FAIL single frame0: got %h expected 0", frame_at(0)); end
        if (frame_at(1) !== exp_frame(24'h123456)) begin
            errors++; $display("FAIL single frame1: got %h expected %h", frame_at(1), exp_frame(24'h123456));
        end
        if (ur_at(1) !== 0) begin errors++; $display("FAIL single ur1: got %0d expected 0", ur_at(1)); end
    endtask

    task automatic test_saturation();
        logic [23:0] hi, lo;
`ifdef EQ_I2S_TX_SATURATE_EN
        hi = 24'h7FFFFF;
        lo = 24'h800000;
`else
        hi = 24'hFF0000;
        lo = 24'h000000;
`endif
        apply_reset();
        send(48'h7FFF_0000_0000, "sat_hi");
        send(48'h8000_0000_0000, "sat_lo");
        wait_frames(3);
        checks += 4;
        if (frame_at(1) !== exp_frame(hi)) begin errors++; $display("FAIL sat_hi frame: got %h expected %h", frame_at(1), exp_frame(hi)); end
        if (frame_at(2) !== exp_frame(lo)) begin errors++; $display("FAIL sat_lo frame: got %h expected %h", frame_at(2), exp_frame(lo)); end
        if (ur_at(1) !== 0) begin errors++; $display("FAIL sat ur1: got %0d expected 0", ur_at(1)); end
        if (ur_at(2) !== 0) begin errors++; $display("FAIL sat ur2: got %0d expected 0", ur_at(2)); end
    endtask

    task automatic test_underrun();
        apply_reset();
        send(48'h0000_0001_0000, "underrun");
        wait_frames(3);
        checks += 4;
        if (frame_at(1) !== exp_frame(24'h000001)) begin errors++; $display("FAIL underrun frame1: got %h expected %h", frame_at(1), exp_frame(24'h000001)); end
        if (frame_at(2) !== exp_frame(24'h000001)) begin errors++; $display("FAIL underrun repeat: got %h expected %h", frame_at(2), exp_frame(24'h000001)); end
        if (ur_at(1) !== 0) begin errors++; $display("FAIL underrun ur1: got %0d expected 0", ur_at(1)); end
        if (ur_at(2) !== 1) begin errors++; $display("FAIL underrun pulse: got %0d expected 1", ur_at(2)); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        send(48'h00AB_CDEF_0000, "b2b_s1");
        send(48'hFFFF_FFFF_0000, "b2b_s2");
        checks++;
        if (cyc !== FRAME + 1) begin errors++; $display("FAIL b2b s2_accept_cyc: got %0d expected %0d", cyc, FRAME + 1); end
        send(48'h0055_5555_0000, "b2b_s3");
        checks++;
        if (cyc !== 2 * FRAME + 1) begin errors++; $display("FAIL b2b s3_accept_cyc: got %0d expected %0d", cyc, 2 * FRAME + 1); end
        wait_frames(4);
        checks += 6;
        if (frame_at(1) !== exp_frame(24'hABCDEF)) begin errors++; $display("FAIL b2b frame1: got %h expected %h", frame_at(1), exp_frame(24'hABCDEF)); end
        if (frame_at(2) !== exp_frame(24'hFFFFFF)) begin errors++; $display("FAIL b2b frame2: got %h expected %h", frame_at(2), exp_frame(24'hFFFFFF)); end
        if (frame_at(3) !== exp_frame(24'h555555)) begin errors++; $display("FAIL b2b frame3: got %h expected %h", frame_at(3), exp_frame(24'h555555)); end
        for (int k = 1; k <= 3; k++) begin
            if (ur_at(k) !== 0) begin errors++; $display("FAIL b2b ur%0d: got %0d expected 0", k, ur_at(k)); end
        end
    endtask

    task automatic test_same_cycle();
        apply_reset();
        send(48'h0013_5790_0000, "same_s0");
        wait_cyc(2 * FRAME - 1);
        checks++;
        if (audio_if.o_ready !== 1'b1) begin errors++; $display("FAIL same ready_pre: got %b expected 1", audio_if.o_ready); end
        audio_if.i_valid      = 1'b1;
        audio_if.i_data_audio = 48'h0024_6801_0000;
        @(posedge clk);
        #1;
        audio_if.i_valid = 1'b0;
        checks++;
        if (audio_if.o_ready !== 1'b0) begin errors++; $display("FAIL same ready_post: got %b expected 0", audio_if.o_ready); end
        wait_frames(4);
        checks += 5;
        if (frame_at(1) !== exp_frame(24'h135790)) begin errors++; $display("FAIL same frame1: got %h expected %h", frame_at(1), exp_frame(24'h135790)); end
        if (frame_at(2) !== exp_frame(24'h135790)) begin errors++; $display("FAIL same repeat: got %h expected %h", frame_at(2), exp_frame(24'h135790)); end
        if (frame_at(3) !== exp_frame(24'h246801)) begin errors++; $display("FAIL same late_sample: got %h expected %h", frame_at(3), exp_frame(24'h246801)); end
        if (ur_at(2) !== 1) begin errors++; $display("FAIL same ur2: got %0d expected 1", ur_at(2)); end
        if (ur_at(3) !== 0) begin errors++; $display("FAIL same ur3: got %0d expected 0", ur_at(3)); end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        send(48'h0033_A5F0_0000, "mid_s1");
        send(48'h0012_0000_0000, "mid_s2");
        // posedge 752 is the falling edge entering bit_cnt=30; posedge 756 raises BCLK
        wait_cyc(FRAME + 245);
        checks += 2;
        if (bclk !== 1'b1) begin errors++; $display("FAIL mid pre_bclk: got %b expected 1", bclk); end
        if (audio_if.o_ready !== 1'b0) begin errors++; $display("FAIL mid pre_ready: got %b expected 0", audio_if.o_ready); end
        #1;
        rst_n = 1'b0;
        #1;
        checks += 5;
        if (bclk !== 1'b0)  begin errors++; $display("FAIL mid bclk: got %b expected 0", bclk); end
        if (lrclk !== 1'b0) begin errors++; $display("FAIL mid lrclk: got %b expected 0", lrclk); end
        if (sdata !== 1'b0) begin errors++; $display("FAIL mid sdata: got %b expected 0", sdata); end
        if (audio_if.o_ready !== 1'b1) begin errors++; $display("FAIL mid ready: got %b expected 1", audio_if.o_ready); end
        if (underrun !== 1'b0) begin errors++; $display("FAIL mid underrun: got %b expected 0", underrun); end
        repeat (4) @(negedge clk);
        frame_q.delete();
        ur_q.delete();
        align_err = 0;
        rst_n     = 1'b1;
        wait_frames(2);
        checks += 3;
        if (frame_at(0) !== 64'h0) begin errors++; $display("FAIL mid frame0: got %h expected 0", frame_at(0)); end
        if (frame_at(1) !== 64'h0) begin errors++; $display("FAIL mid frame1: got %h expected 0", frame_at(1)); end
        if (ur_at(1) !== 0) begin errors++; $display("FAIL mid ur1: got %0d expected 0", ur_at(1)); end
    endtask

    initial begin
        audio_if.i_valid      = 1'b0;
        audio_if.i_data_audio = '0;
        test_reset();
        test_single();
        test_saturation();
        test_underrun();
        test_back_to_back();
        test_same_cycle();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
